// File: rtl/execute_mdu.sv
// execute_mdu: ALU/branch/jump, iterative divider, fixed-latency multiplier.
// clk/rstn, start/flush/op/pc/imm/rs1/rs2 in; busy/done/result/jump_* out.
module execute_mdu #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            jump_taken,
  output logic [XLEN-1:0] jump_dest
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd2;
  localparam logic [3:0] OP_BNE   = 4'd3;
  localparam logic [3:0] OP_BLT   = 4'd4;
  localparam logic [3:0] OP_BGEU  = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_JALR  = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULH  = 4'd9;
  localparam logic [3:0] OP_MULHU = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REM   = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, FIX
  } state_t;

  state_t state, nxt;

  logic            pend;
  logic [3:0]      p_op;
  logic [XLEN-1:0] p_pc, p_imm, p_a, p_b;
  logic [XLEN-1:0] dr;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  logic acc, is_mul, is_div, div_sgn;
  logic div_ovf, div_long;

  assign acc     = start && !flush &&
                   (state == IDLE);
  assign is_mul  = op inside {OP_MUL,
                   OP_MULH, OP_MULHU};
  assign is_div  = op inside {OP_DIV,
                   OP_DIVU, OP_REM, OP_REMU};
  assign div_sgn = (op == OP_DIV) ||
                   (op == OP_REM);
  assign div_ovf = div_sgn && (rs1 == MIN) &&
                   (rs2 == '1);
  assign div_long = is_div && (rs2 != '0) &&
                    !div_ovf;

  assign busy = (state != IDLE);

  logic [XLEN-1:0] m1, m2;
  assign m1 = (div_sgn && rs1[XLEN-1]) ?
              -rs1 : rs1;
  assign m2 = (div_sgn && rs2[XLEN-1]) ?
              -rs2 : rs2;

  logic              msgn;
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0]   mul_res;
  assign msgn = (p_op == OP_MULH);
  assign ma = {{XLEN{msgn & p_a[XLEN-1]}}, p_a};
  assign mb = {{XLEN{msgn & p_b[XLEN-1]}}, p_b};
  assign prod = ma * mb;
  assign mul_res = (p_op == OP_MUL) ?
                   prod[XLEN-1:0] :
                   prod[2*XLEN-1:XLEN];

  logic [XLEN:0]   r_sh, diff;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            is_rem;
  assign r_sh  = {dr, p_a[XLEN-1]};
  assign diff  = r_sh - {1'b0, p_b};
  assign q_fix = neg_q ? -p_a : p_a;
  assign r_fix = neg_r ? -dr : dr;
  assign is_rem = (p_op == OP_REM) ||
                  (p_op == OP_REMU);

  // Single-cycle ops, incl. the divide
  // corner cases that skip iteration.
  function automatic logic [2*XLEN:0]
    fast_eval(
      input logic [3:0]      o,
      input logic [XLEN-1:0] p,
      input logic [XLEN-1:0] im,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
    );
    logic [XLEN-1:0] r, d, t;
    logic            j;
    r = '0;
    d = '0;
    j = 1'b0;
    t = a + im;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_BEQ:  j = (a == b);
      OP_BNE:  j = (a != b);
      OP_BLT:  j = ($signed(a) < $signed(b));
      OP_BGEU: j = (a >= b);
      OP_JAL: begin
        r = p + XLEN'(4);
        j = 1'b1;
        d = p + im;
      end
      OP_JALR: begin
        r = p + XLEN'(4);
        j = 1'b1;
        d = {t[XLEN-1:1], 1'b0};
      end
      OP_DIV, OP_DIVU:
        r = (b == '0) ? '1 : a;
      OP_REM, OP_REMU:
        r = (b == '0) ? a : '0;
      default: r = '0;
    endcase
    if (o inside {OP_BEQ, OP_BNE,
                  OP_BLT, OP_BGEU}) begin
      r = {{(XLEN-1){1'b0}}, j};
      d = j ? (p + im) : '0;
    end
    return {j, d, r};
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (acc && is_mul)   nxt = MUL;
        if (acc && div_long) nxt = DIV;
      end
      MUL:
        if (cnt == CW'(MUL_LATENCY - 1))
          nxt = IDLE;
      DIV:
        if (cnt == CW'(XLEN - 1)) nxt = FIX;
      FIX:
        if (cnt == CW'(1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      done       <= 1'b0;
      result     <= '0;
      jump_taken <= 1'b0;
      jump_dest  <= '0;
      pend       <= 1'b0;
      p_op       <= '0;
      p_pc       <= '0;
      p_imm      <= '0;
      p_a        <= '0;
      p_b        <= '0;
      dr         <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        pend <= 1'b0;
        cnt  <= '0;
      end else begin
        pend <= acc && !is_mul && !div_long;
        if (pend) begin
          done <= 1'b1;
          {jump_taken, jump_dest, result} <=
            fast_eval(p_op, p_pc, p_imm,
                      p_a, p_b);
        end
        if (acc) begin
          p_op  <= op;
          p_pc  <= pc;
          p_imm <= imm;
          cnt   <= '0;
          dr    <= '0;
          neg_q <= div_sgn &&
                   (rs1[XLEN-1] ^ rs2[XLEN-1]);
          neg_r <= div_sgn && rs1[XLEN-1];
          if (div_long) begin
            p_a <= m1;
            p_b <= m2;
          end else begin
            p_a <= rs1;
            p_b <= rs2;
          end
        end
        unique case (state)
          IDLE: ;
          MUL: begin
            if (cnt == CW'(MUL_LATENCY - 1)) begin
              done       <= 1'b1;
              result     <= mul_res;
              jump_taken <= 1'b0;
              jump_dest  <= '0;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DIV: begin
            // p_a shifts dividend out and
            // quotient bits in.
            if (!diff[XLEN]) begin
              dr  <= diff[XLEN-1:0];
              p_a <= {p_a[XLEN-2:0], 1'b1};
            end else begin
              dr  <= r_sh[XLEN-1:0];
              p_a <= {p_a[XLEN-2:0], 1'b0};
            end
            if (cnt == CW'(XLEN - 1))
              cnt <= '0;
            else
              cnt <= cnt + 1'b1;
          end
          FIX: begin
            // Signed result registered
            // first, then published.
            if (cnt == '0) begin
              p_a <= is_rem ? r_fix : q_fix;
              cnt <= CW'(1);
            end else begin
              done       <= 1'b1;
              result     <= p_a;
              jump_taken <= 1'b0;
              jump_dest  <= '0;
              cnt        <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/execute_mdu.md
EXECUTE_MDU -- requirements
Module: execute_mdu

Interface
REQ-001 Parameter XLEN, default 32: datapath width of operands, result and jump destination; legal values 32 and 64.
REQ-002 Parameter MUL_LATENCY, default 2: cycles from accepted start to done for MUL/MULH/MULHU; legal range 1..4.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request pulse; op/operands sampled on the same edge.
REQ-006 flush  input  1  abort in-flight operation (pipeline redirect).
REQ-007 op  input  4  operation code: 0 ADD, 1 SUB, 2 BEQ, 3 BNE, 4 BLT, 5 BGEU, 6 JAL, 7 JALR, 8 MUL, 9 MULH, 10 MULHU, 11 DIV, 12 DIVU, 13 REM, 14 REMU, 15 reserved.
REQ-008 pc  input  XLEN  address of the instruction.
REQ-009 imm  input  XLEN  sign-extended immediate.
REQ-010 rs1, rs2  input  XLEN each  source operand values.
REQ-011 busy  output  1  high while an accepted operation has not completed.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 result  output  XLEN  operation result, valid when done is high.
REQ-014 jump_taken  output  1  control transfer required, valid when done is high.
REQ-015 jump_dest  output  XLEN  control transfer target, valid when done is high.

Function
REQ-016 State machine states: IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-017 start is accepted only in IDLE with flush low; start while busy is ignored, and in-flight operands are not disturbed.
REQ-018 Latency L = cycles from accepting edge to the edge that raises done; done is high for exactly one cycle.
REQ-019 Ops 0-7 and 15: L=1, stay IDLE, busy stays low.
REQ-020 Ops 8-10: IDLE->MUL, L=MUL_LATENCY; MUL->IDLE on final count; busy high from accepting edge until done edge.
REQ-021 Ops 11-14, divisor nonzero and not signed overflow: IDLE->DIV (operand magnitudes latched), XLEN restoring iterations one quotient bit per cycle, DIV->FIX, FIX applies signs, FIX->IDLE; L=XLEN+2.
REQ-022 Divide by zero: quotient all ones, remainder = rs1; L=1, no DIV state.
REQ-023 Signed overflow (rs1 = most-negative, rs2 = all ones, op 11/13): quotient = rs1, remainder 0; L=1.
REQ-024 Signed division truncates toward zero; remainder sign follows dividend.
REQ-025 ADD/SUB modulo 2^XLEN; MUL returns low XLEN bits of product; MULH returns high XLEN bits signed x signed; MULHU returns high XLEN bits unsigned x unsigned.
REQ-026 Branches 2-5: result = 1 if condition true else 0 (BLT signed, BGEU unsigned); jump_taken = result; jump_dest = pc+imm if taken else 0.
REQ-027 JAL: result = pc+4, jump_taken 1, jump_dest = pc+imm; JALR: result = pc+4, jump_taken 1, jump_dest = (rs1+imm) with bit 0 cleared.
REQ-028 All non-control ops and op 15: jump_taken 0, jump_dest 0; op 15 result 0.
REQ-029 result, jump_taken, jump_dest update only on the done edge and hold until next done.
REQ-030 flush high in any state: next state IDLE, busy low, no done for the aborted op; outputs keep previous values.
REQ-031 flush and start in the same cycle: flush wins, start ignored.
REQ-032 flush on the cycle done would otherwise rise: done suppressed, outputs not updated.
REQ-033 A new start is accepted on the same edge as which done is raised only if state is IDLE before that edge (i.e. single-cycle ops back-to-back: one op per cycle).

Reset
REQ-034 rstn low at a clock edge: state IDLE, busy 0, done 0, result 0, jump_taken 0, jump_dest 0, counters 0, regardless of operation in flight.
REQ-035 No done pulse is produced for an operation interrupted by reset.

Verification
REQ-036 ADD rs1=0xFFFFFFFF rs2=1 then BNE rs1=3 rs2=4 pc=0x100 imm=0x20 on consecutive cycles -> done two consecutive cycles, result 0 then 1, second jump_taken 1 jump_dest 0x120.
REQ-037 JALR pc=0x200 rs1=0x1001 imm=4 -> result 0x204, jump_taken 1, jump_dest 0x1004, L=1.
REQ-038 MULH rs1=0x80000000 rs2=2 (MUL_LATENCY=2) -> done 2 cycles after start, result 0xFFFFFFFF; MULHU same operands -> 0x00000001.
REQ-039 DIV rs1=-7 rs2=2 -> done at L=34, result 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU rs2=0 -> 0xFFFFFFFF at L=1; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000 at L=1.
REQ-040 DIVU started, flush asserted at cycle 10, new ADD started cycle 12 -> no done for DIVU, ADD done at cycle 13 with correct sum; start pulses during DIV ignored.
REQ-041 rstn low during DIV iteration 5 -> next cycle all outputs 0, busy 0, no subsequent done until a new start.
